decoder: RTL and testbench
==========================

Name: decoder

Overview:
- Unpacking stage feeding the polynomial datapath.
- Accepts a stream of W-bit packed words (t0, t1, s1/s2, w1, z) and accumulates them in a 256-bit serial-in/parallel-out buffer.
- Emits OUTPUT_W coefficients per beat: bit-sliced, recentred, reduced mod q.
- Exact inverse of the packing encoder; both share the same level/mode table.

Parameters:
OUTPUT_W, 4, coefficients emitted per output beat
COEFF_W, 23, width of each output coefficient (mod q)
MAX_LVL, 20, largest packed coefficient width in bits
W, 64, input word width

Ports:
clk  input  1  system clock
rst  input  1  reset; synchronous, active-high
sec_lvl  input  3  Dilithium level: 2, 3 or 5; static while a polynomial is in flight
decode_mode  input  3  0=T0, 1=T1, 2=S1, 3=S2, 4=W1, 5=Z; static while a polynomial is in flight
valid_i  input  1  di valid
ready_i  output  1  word accepted when valid_i && ready_i
di  input  W  packed word, LSB first
dout  output  OUTPUT_W*COEFF_W  coefficient lane i at [23*i +: 23], lane 0 = earliest coefficient
valid_o  output  1  dout valid
ready_o  input  1  downstream accept

Behaviour:
- Level/mode table (LVL bits per coefficient; centring constant C):
  - T0: 13, C=4096
  - T1: 10, raw
  - S1/S2 at lvl 2/5: 3, C=eta=2
  - S1/S2 at lvl 3: 4, C=eta=4
  - W1 at lvl 2: 6, raw
  - W1 at lvl 3/5: 4, raw
  - Z at lvl 2: 18, C=2^17
  - Z at lvl 3/5: 20, C=2^19
  - Undefined combinations: LVL=0; never valid.
- Centring: out = C - x; if negative, add q (8380417). Raw modes zero-extend x to 23 bits.
- SIPO buffer: 256-bit register plus 9-bit fill count `len`.
  - Append: buf |= di << len_after_pop.
  - Pop: buf >>= 4*LVL.
  - Pop and append in the same cycle are allowed; the pop applies first.
- ready_i = (len <= 256-W), i.e. len <= 192. Combinational from state only; no dependence on valid_i.
- Output register stage:
  - Loads when len >= 4*LVL && (!valid_o || ready_o).
  - Load takes the low 4*LVL bits, split into OUTPUT_W fields of LVL bits each, centred per lane.
  - On load: valid_o <= 1 and the pop is performed.
  - If valid_o && ready_o and nothing is loadable: valid_o <= 0.
  - dout holds stable while valid_o && !ready_o.
- Latency: word accepted at edge t is in the buffer at t+1. First dout valid after edge t+1, i.e. visible in cycle t+1 → t+2 when len >= 4*LVL.
- Throughput: one beat per cycle while the buffer holds enough bits. Steady state is input-limited for LVL >= 16.
- Every polynomial packs to a whole number of words (256*LVL is a multiple of 64). The buffer is therefore empty at polynomial end; no flush is needed.
- Reset (synchronous): len=0, buf=0, valid_o=0, dout=0. A reset mid-polynomial discards all buffered bits. ready_i is 1 in the cycle after reset.
- Boundary cases:
  - len=192 with valid_i: accept (len→256).
  - len=193..256: ready_i=0.
  - LVL=0 mode: never loads; ready_i still follows len.

Decomposition:
- Shared package `dilithium_pkg`:
  - DILITHIUM_Q
  - encode/decode mode codes (T0..Z)
  - sec-level codes
  - function lvl_of(sec_lvl, mode)
  - function centre_of(sec_lvl, mode)
  - These are also used by the encoder.
- One sub-module `recenter_coeff`: combinational (sec_lvl, mode, x[19:0]) → 23-bit value mod q. Instantiated OUTPUT_W times.

Test Plan:
- W1, lvl 3, di=64'h0000_0000_8765_4321, ready_o=1 → beat 0 dout lanes {1,2,3,4}, beat 1 {5,6,7,8}, then 0s; valid_o first high 2 cycles after the accept.
- S1, lvl 2, first 12 bits of di = 3'b100,3'b000,3'b001,3'b010 (lane0=x=2 ... ) → lanes {0,2,1,8380415} for x=2,0,1,4.
- T0, lane x=0 → 4096; x=8191 → 8376322; x=4096 → 0.
- Z, lvl 2, 72 words of all-zero data → 64 beats all lanes = 131072; len returns to 0; no extra valid_o.
- Backpressure: ready_o=0, stream W1 lvl 3 words continuously → ready_i drops after the 4th word (len=240 after pop of 16); dout stable; releasing ready_o drains in order with no lost or duplicated beats.
- Assert rst with len=136 mid-T1 stream → next cycle valid_o=0, ready_i=1; a fresh polynomial decodes correctly.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and the packing level/mode table.
// Both the packing encoder and the unpacking decoder use this table.
package dilithium_pkg;

    localparam int unsigned DILITHIUM_Q = 8380417;

    typedef enum logic [2:0] {
        MODE_T0 = 3'd0,
        MODE_T1 = 3'd1,
        MODE_S1 = 3'd2,
        MODE_S2 = 3'd3,
        MODE_W1 = 3'd4,
        MODE_Z  = 3'd5
    } coder_mode_e;

    typedef enum logic [2:0] {
        SEC_LVL2 = 3'd2,
        SEC_LVL3 = 3'd3,
        SEC_LVL5 = 3'd5
    } sec_lvl_e;

    typedef struct packed {
        logic        centred;
        logic [19:0] c;
    } centre_t;

    function automatic logic sec_ok(input logic [2:0] sec);
        return (sec == SEC_LVL2) || (sec == SEC_LVL3) || (sec == SEC_LVL5);
    endfunction

    // Bits per packed coefficient; 0 marks an undefined level/mode pair.
    function automatic logic [4:0] lvl_of(input logic [2:0] sec, input logic [2:0] mode);
        logic [4:0] l;
        l = 5'd0;
        if (sec_ok(sec)) begin
            case (mode)
                MODE_T0:          l = 5'd13;
                MODE_T1:          l = 5'd10;
                MODE_S1, MODE_S2: l = (sec == SEC_LVL3) ? 5'd4 : 5'd3;
                MODE_W1:          l = (sec == SEC_LVL2) ? 5'd6 : 5'd4;
                MODE_Z:           l = (sec == SEC_LVL2) ? 5'd18 : 5'd20;
                default:          l = 5'd0;
            endcase
        end
        return l;
    endfunction

    function automatic centre_t centre_of(input logic [2:0] sec, input logic [2:0] mode);
        centre_t r;
        r = '0;
        case (mode)
            MODE_T0:          r = '{centred: 1'b1, c: 20'd4096};
            MODE_S1, MODE_S2: r = '{centred: 1'b1, c: (sec == SEC_LVL3) ? 20'd4 : 20'd2};
            MODE_Z:           r = '{centred: 1'b1, c: (sec == SEC_LVL2) ? 20'd131072 : 20'd524288};
            default:          r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/recenter_coeff.sv
// Maps one unpacked field to its coefficient: C - x reduced into [0, q),
// or the zero-extended field itself for raw modes.
module recenter_coeff
    import dilithium_pkg::*;
(
    input  logic [2:0]  sec_lvl,
    input  logic [2:0]  mode,
    input  logic [19:0] x,
    output logic [22:0] coeff
);

    centre_t     ctr;
    logic [23:0] diff;

    // C and x are both below 2^20, so a single conditional add of q suffices.
    always_comb begin
        ctr  = centre_of(sec_lvl, mode);
        diff = {4'd0, ctr.c} - {4'd0, x};
        if (!ctr.centred) begin
            coeff = {3'd0, x};
        end else if (diff[23]) begin
            coeff = 23'(diff + 24'(DILITHIUM_Q));
        end else begin
            coeff = diff[22:0];
        end
    end

endmodule

// File: rtl/decoder.sv
// Unpacking stage: SIPO bit buffer fed by W-bit words, emitting OUTPUT_W
// recentred coefficients per beat through a ready/valid output register.
module decoder
    import dilithium_pkg::*;
#(
    parameter int OUTPUT_W = 4,
    parameter int COEFF_W  = 23,
    parameter int MAX_LVL  = 20,
    parameter int W        = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [2:0]                  sec_lvl,
    input  logic [2:0]                  decode_mode,
    input  logic                        valid_i,
    output logic                        ready_i,
    input  logic [W-1:0]                di,
    output logic [OUTPUT_W*COEFF_W-1:0] dout,
    output logic                        valid_o,
    input  logic                        ready_o
);

    localparam int BUF_W = 256;

    logic [BUF_W-1:0]            sipo_q;
    logic [BUF_W-1:0]            sipo_d;
    logic [BUF_W-1:0]            popped;
    logic [8:0]                  len_q;
    logic [8:0]                  len_d;
    logic [8:0]                  len_after_pop;
    logic [8:0]                  beat_bits;
    logic [4:0]                  lvl;
    logic [MAX_LVL:0]            lvl_one;
    logic [MAX_LVL-1:0]          lvl_mask;
    logic                        loadable;
    logic                        load;
    logic                        accept;
    logic [MAX_LVL-1:0]          field [OUTPUT_W];
    logic [22:0]                 lane_coeff [OUTPUT_W];
    logic [OUTPUT_W*COEFF_W-1:0] dout_d;

    assign ready_i = (len_q <= 9'(BUF_W - W));

    // Buffer control: the pop of a loaded beat is applied before the new word
    // is appended, so the word lands directly above the remaining bits.
    always_comb begin
        lvl           = lvl_of(sec_lvl, decode_mode);
        beat_bits     = 9'(OUTPUT_W) * {4'd0, lvl};
        loadable      = (lvl != 5'd0) && (len_q >= beat_bits);
        load          = loadable && (!valid_o || ready_o);
        accept        = valid_i && ready_i;
        len_after_pop = load ? (len_q - beat_bits) : len_q;
        popped        = load ? (sipo_q >> beat_bits) : sipo_q;
        sipo_d        = popped;
        len_d         = len_after_pop;
        if (accept) begin
            sipo_d = popped | ({{(BUF_W-W){1'b0}}, di} << len_after_pop);
            len_d  = len_after_pop + 9'(W);
        end
    end

    always_comb begin
        lvl_one  = (MAX_LVL+1)'(1) << lvl;
        lvl_mask = MAX_LVL'(lvl_one - (MAX_LVL+1)'(1));
        for (int i = 0; i < OUTPUT_W; i++) begin
            field[i] = MAX_LVL'(sipo_q >> (9'(i) * {4'd0, lvl})) & lvl_mask;
        end
    end

    for (genvar g = 0; g < OUTPUT_W; g++) begin : g_lane
        recenter_coeff u_recenter (
            .sec_lvl (sec_lvl),
            .mode    (decode_mode),
            .x       (20'(field[g])),
            .coeff   (lane_coeff[g])
        );
    end

    always_comb begin
        dout_d = '0;
        for (int i = 0; i < OUTPUT_W; i++) begin
            dout_d[i*COEFF_W +: COEFF_W] = COEFF_W'(lane_coeff[i]);
        end
    end

    // Output register holds dout while stalled and drops valid only when drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            sipo_q  <= '0;
            len_q   <= '0;
            valid_o <= 1'b0;
            dout    <= '0;
        end else begin
            sipo_q <= sipo_d;
            len_q  <= len_d;
            if (load) begin
                dout    <= dout_d;
                valid_o <= 1'b1;
            end else if (valid_o && ready_o) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decoder.sv
// Self-checking bench for decoder: constant vector table, directed latency,
// backpressure and reset sequences, and randomized polynomials per mode.
module tb_decoder;

    localparam int OUTPUT_W = 4;
    localparam int COEFF_W  = 23;
    localparam int MAX_LVL  = 20;
    localparam int W        = 64;
    localparam int Q        = 8380417;
    localparam int DW       = OUTPUT_W * COEFF_W;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    sec_lvl;
    logic [2:0]    decode_mode;
    logic          valid_i;
    logic          ready_i;
    logic [W-1:0]  di;
    logic [DW-1:0] dout;
    logic          valid_o;
    logic          ready_o;

    int checks   = 0;
    int failures = 0;

    bit            model_bits[$];
    logic [DW-1:0] exp_beats[$];

    always #5 clk = ~clk;

    decoder #(
        .OUTPUT_W (OUTPUT_W),
        .COEFF_W  (COEFF_W),
        .MAX_LVL  (MAX_LVL),
        .W        (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sec_lvl     (sec_lvl),
        .decode_mode (decode_mode),
        .valid_i     (valid_i),
        .ready_i     (ready_i),
        .di          (di),
        .dout        (dout),
        .valid_o     (valid_o),
        .ready_o     (ready_o)
    );

    // Reference table: bits per coefficient and centring constant (-1 = raw).
    function automatic int tb_lvl(input int sec, input int mode);
        if (!(sec == 2 || sec == 3 || sec == 5)) return 0;
        case (mode)
            0:       return 13;
            1:       return 10;
            2, 3:    return (sec == 3) ? 4 : 3;
            4:       return (sec == 2) ? 6 : 4;
            5:       return (sec == 2) ? 18 : 20;
            default: return 0;
        endcase
    endfunction

    function automatic int tb_centre(input int sec, input int mode);
        case (mode)
            0:       return 4096;
            2, 3:    return (sec == 3) ? 4 : 2;
            5:       return (sec == 2) ? 131072 : 524288;
            default: return -1;
        endcase
    endfunction

    function automatic int exp_coeff(input int sec, input int mode, input int x);
        int c;
        int v;
        c = tb_centre(sec, mode);
        if (c < 0) return x;
        v = c - x;
        if (v < 0) v = v + Q;
        return v;
    endfunction

    task automatic model_push(input logic [W-1:0] w);
        int            l;
        int            x;
        logic [DW-1:0] beat;
        for (int i = 0; i < W; i++) model_bits.push_back(w[i]);
        l = tb_lvl(int'(sec_lvl), int'(decode_mode));
        while (l > 0 && model_bits.size() >= OUTPUT_W * l) begin
            beat = '0;
            for (int lane = 0; lane < OUTPUT_W; lane++) begin
                x = 0;
                for (int b = 0; b < l; b++) x = x | (int'(model_bits.pop_front()) << b);
                beat[lane*COEFF_W +: COEFF_W] =
                    COEFF_W'(exp_coeff(int'(sec_lvl), int'(decode_mode), x));
            end
            exp_beats.push_back(beat);
        end
    endtask

    task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then score the
    // handshakes that will happen at the following rising edge.
    task automatic applyStimulus(input logic v, input logic [W-1:0] d, input logic r,
                                 output logic acc, output logic bt);
        @(negedge clk);
        valid_i = v;
        di      = d;
        ready_o = r;
        #1;
        bt = valid_o && ready_o;
        if (bt) begin
            if (exp_beats.size() == 0) begin
                checkOutput("unexpected_beat", dout, '0);
                if (dout === '0) begin
                    failures++;
                    $display("[TB] FAIL unexpected_beat: got beat expected none");
                end
            end else begin
                checkOutput("beat", dout, exp_beats.pop_front());
            end
        end
        acc = valid_i && ready_i;
        if (acc) model_push(d);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_o = 1'b0;
        di      = '0;
        @(negedge clk);
        rst = 1'b0;
        model_bits.delete();
        exp_beats.delete();
        #1;
    endtask

    task automatic runPoly(input int sec, input int mode);
        int   l;
        int   nwords;
        int   sent;
        int   beats;
        int   cyc;
        logic acc;
        logic bt;
        logic v;
        doReset();
        sec_lvl     = 3'(sec);
        decode_mode = 3'(mode);
        l      = tb_lvl(sec, mode);
        nwords = OUTPUT_W * l;
        sent   = 0;
        beats  = 0;
        cyc    = 0;
        while ((sent < nwords || beats < 64) && cyc < 3000) begin
            v = (sent < nwords) && ($urandom_range(0, 3) != 0);
            applyStimulus(v, {$urandom, $urandom}, ($urandom_range(0, 3) != 0), acc, bt);
            if (acc) sent++;
            if (bt) beats++;
            cyc++;
        end
        checkValue($sformatf("poly_beats_s%0d_m%0d", sec, mode), beats, 64);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b1, acc, bt);
        checkValue($sformatf("poly_idle_s%0d_m%0d", sec, mode), int'(valid_o), 0);
        checkValue($sformatf("poly_empty_s%0d_m%0d", sec, mode), exp_beats.size(), 0);
    endtask

    typedef struct {
        string         name;
        logic [2:0]    sec;
        logic [2:0]    mode;
        logic [W-1:0]  w0;
        logic [W-1:0]  w1;
        logic [DW-1:0] lanes;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic acc;
        logic bt;
        int   n;
        int   sent;
        int   beats;

        rst = 1'b0; valid_i = 1'b0; ready_o = 1'b0; di = '0;
        sec_lvl = 3'd2; decode_mode = 3'd0;

        vecs[0] = '{"w1_l3", 3'd3, 3'd4, 64'h0000_0000_8765_4321, 64'h0,
                    {23'd4, 23'd3, 23'd2, 23'd1}};
        vecs[1] = '{"s1_l2", 3'd2, 3'd2, 64'h0000_0000_0000_0842, 64'h0,
                    {23'd8380415, 23'd1, 23'd2, 23'd0}};
        vecs[2] = '{"t0_l2", 3'd2, 3'd0, 64'h0000_00C0_03FF_E000, 64'h0,
                    {23'd4095, 23'd0, 23'd8376322, 23'd4096}};
        vecs[3] = '{"t1_l5", 3'd5, 3'd1, 64'h0000_0000_3FF0_0801, 64'h0,
                    {23'd0, 23'd1023, 23'd2, 23'd1}};
        vecs[4] = '{"s2_l3", 3'd3, 3'd3, 64'h0000_0000_0000_F840, 64'h0,
                    {23'd8380406, 23'd8380413, 23'd0, 23'd4}};
        vecs[5] = '{"w1_l2", 3'd2, 3'd4, 64'h0000_0000_00A8_503F, 64'h0,
                    {23'd42, 23'd5, 23'd0, 23'd63}};
        vecs[6] = '{"z_l5", 3'd5, 3'd5, 64'h1FFF_FF80_0000_0000, 64'h0,
                    {23'd524287, 23'd7856130, 23'd0, 23'd524288}};

        doReset();
        checkValue("reset_valid_o", int'(valid_o), 0);
        checkValue("reset_ready_i", int'(ready_i), 1);
        checkOutput("reset_dout", dout, '0);

        // Vector table: first beat of each entry, held with ready_o low.
        foreach (vecs[k]) begin
            doReset();
            sec_lvl     = vecs[k].sec;
            decode_mode = vecs[k].mode;
            applyStimulus(1'b1, vecs[k].w0, 1'b0, acc, bt);
            applyStimulus(1'b1, vecs[k].w1, 1'b0, acc, bt);
            n = 0;
            while (!valid_o && n < 10) begin
                applyStimulus(1'b0, '0, 1'b0, acc, bt);
                n++;
            end
            checkValue({vecs[k].name, "_valid"}, int'(valid_o), 1);
            checkOutput(vecs[k].name, dout, vecs[k].lanes);
        end

        // Latency and beat order for a single W1 word.
        doReset();
        sec_lvl = 3'd3; decode_mode = 3'd4;
        applyStimulus(1'b1, 64'h0000_0000_8765_4321, 1'b1, acc, bt);
        checkValue("lat_accept", int'(acc), 1);
        applyStimulus(1'b0, '0, 1'b1, acc, bt);
        checkValue("lat_not_yet", int'(valid_o), 0);
        applyStimulus(1'b0, '0, 1'b1, acc, bt);
        checkValue("lat_valid", int'(valid_o), 1);
        checkOutput("lat_beat0", dout, {23'd4, 23'd3, 23'd2, 23'd1});
        applyStimulus(1'b0, '0, 1'b1, acc, bt);
        checkOutput("lat_beat1", dout, {23'd8, 23'd7, 23'd6, 23'd5});
        applyStimulus(1'b0, '0, 1'b1, acc, bt);
        checkOutput("lat_beat2", dout, '0);
        applyStimulus(1'b0, '0, 1'b1, acc, bt);
        checkOutput("lat_beat3", dout, '0);
        applyStimulus(1'b0, '0, 1'b1, acc, bt);
        checkValue("lat_drained", int'(valid_o), 0);

        // Z level 2: 72 all-zero words give 64 beats of 2^17.
        doReset();
        sec_lvl = 3'd2; decode_mode = 3'd5;
        sent = 0; beats = 0; n = 0;
        while (sent < 72 && n < 500) begin
            applyStimulus(1'b1, '0, 1'b1, acc, bt);
            if (acc) sent++;
            if (bt) beats++;
            n++;
        end
        checkValue("z_sent", sent, 72);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, '0, 1'b1, acc, bt);
            if (bt) beats++;
        end
        checkValue("z_beats", beats, 64);
        checkValue("z_valid_end", int'(valid_o), 0);
        checkValue("z_ready_end", int'(ready_i), 1);

        // Backpressure: buffer fills to 240 bits, then drains in order.
        doReset();
        sec_lvl = 3'd3; decode_mode = 3'd4;
        sent = 0; beats = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, {$urandom, $urandom}, 1'b0, acc, bt);
            if (acc) sent++;
        end
        checkValue("bp_accepted", sent, 4);
        checkValue("bp_ready_low", int'(ready_i), 0);
        checkValue("bp_valid", int'(valid_o), 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, acc, bt);
        checkOutput("bp_hold", dout, exp_beats[0]);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, '0, 1'b1, acc, bt);
            if (bt) beats++;
        end
        checkValue("bp_beats", beats, 16);
        checkValue("bp_empty", exp_beats.size(), 0);

        // Undefined mode never loads; len=192 still accepts, 256 blocks.
        doReset();
        sec_lvl = 3'd2; decode_mode = 3'd6;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, acc, bt);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, acc, bt);
        checkValue("lvl0_accept_192", int'(acc), 1);
        applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, acc, bt);
        checkValue("lvl0_full_ready", int'(ready_i), 0);
        checkValue("lvl0_no_valid", int'(valid_o), 0);

        // Reset in the middle of a T1 stream, then a clean polynomial.
        doReset();
        sec_lvl = 3'd2; decode_mode = 3'd1;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, {$urandom, $urandom}, 1'b1, acc, bt);
        doReset();
        checkValue("midrst_valid_o", int'(valid_o), 0);
        checkValue("midrst_ready_i", int'(ready_i), 1);
        runPoly(2, 1);

        // Randomized full polynomials for every level/mode pair.
        foreach (vecs[k]) begin
            runPoly(int'(vecs[k].sec), int'(vecs[k].mode));
        end
        for (int s = 0; s < 3; s++) begin
            for (int m = 0; m < 6; m++) begin
                runPoly((s == 0) ? 2 : (s == 1) ? 3 : 5, m);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
